// File: rtl/mc_issue_arbiter_if.sv
// Bundle of signals between the two instruction requesters, the issue
// arbiter and the Maincontroller. The master side drives the requests,
// the instructions and the controller overflow flag. The slave side
// (the arbiter) drives the grants, completions and controller controls.
interface mc_issue_arbiter_if;
    logic        REQ0;
    logic [10:0] INST0;
    logic        GNT0;
    logic        DONE0;
    logic        OVF0;
    logic        REQ1;
    logic [10:0] INST1;
    logic        GNT1;
    logic        DONE1;
    logic        OVF1;
    logic [10:0] MC_INST;
    logic        MC_EN;
    logic        MC_RST;
    logic        MC_OV;

    modport master (
        output REQ0, INST0, REQ1, INST1, MC_OV,
        input  GNT0, DONE0, OVF0, GNT1, DONE1, OVF1, MC_INST, MC_EN, MC_RST
    );

    modport slave (
        input  REQ0, INST0, REQ1, INST1, MC_OV,
        output GNT0, DONE0, OVF0, GNT1, DONE1, OVF1, MC_INST, MC_EN, MC_RST
    );
endinterface

// File: rtl/mc_issue_arbiter.sv
// Round-robin issue arbiter that shares one Maincontroller between two
// requesters. The winning instruction is held on MC_INST with MC_EN high
// for an opcode-dependent number of cycles. The controller is then cleared
// with MC_RST, and completion plus overflow go back to the owner.
// Every output is driven straight from a register. The next value is
// computed together with the next state.
module mc_issue_arbiter #(
    parameter int unsigned READ_CYC  = 3,
    parameter int unsigned WRITE_CYC = 3,
    parameter int unsigned ALU_CYC   = 6,
    parameter int unsigned CLR_CYC   = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    mc_issue_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // Number of cycles MC_EN stays high after ISSUE for a given opcode.
    // Add (10) and sub (11) share the ALU duration.
    function automatic logic [3:0] op_cycles(input logic [1:0] op);
        logic [3:0] n;
        case (op)
            2'b00:   n = 4'(READ_CYC);
            2'b01:   n = 4'(WRITE_CYC);
            2'b10:   n = 4'(ALU_CYC);
            2'b11:   n = 4'(ALU_CYC);
            default: n = 4'(ALU_CYC);
        endcase
        return n;
    endfunction

    // State and bookkeeping registers.
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_owner;
    logic        r_rr_ptr;
    logic [10:0] r_inst;

    // Output registers.
    logic        r_gnt0, r_gnt1;
    logic        r_done0, r_done1;
    logic        r_ovf0, r_ovf1;
    logic [10:0] r_mc_inst;
    logic        r_mc_en;
    logic        r_mc_rst;

    // Next-state and next-output values.
    state_t      w_state_nx;
    logic [3:0]  w_cnt_nx;
    logic        w_owner_nx;
    logic        w_rr_ptr_nx;
    logic [10:0] w_inst_nx;
    logic        w_gnt0_nx, w_gnt1_nx;
    logic        w_done0_nx, w_done1_nx;
    logic        w_ovf0_nx, w_ovf1_nx;
    logic [10:0] w_mc_inst_nx;
    logic        w_mc_en_nx;
    logic        w_mc_rst_nx;

    // Arbitration: a lone request wins outright, and a tie goes to rr_ptr.
    logic        w_req_any;
    logic        w_win_id;
    logic [10:0] w_win_inst;
    logic        w_ov;

    assign w_req_any  = bus.REQ0 | bus.REQ1;
    assign w_win_id   = (bus.REQ0 & bus.REQ1) ? r_rr_ptr : bus.REQ1;
    assign w_win_inst = w_win_id ? bus.INST1 : bus.INST0;
    // Only ALU opcodes (bit 10 set) can report an overflow.
    assign w_ov       = bus.MC_OV & r_inst[10];

    // Next-state and next-output logic for the issue sequence.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_owner_nx   = r_owner;
        w_rr_ptr_nx  = r_rr_ptr;
        w_inst_nx    = r_inst;
        w_gnt0_nx    = 1'b0;
        w_gnt1_nx    = 1'b0;
        w_done0_nx   = 1'b0;
        w_done1_nx   = 1'b0;
        w_ovf0_nx    = 1'b0;
        w_ovf1_nx    = 1'b0;
        w_mc_inst_nx = 11'd0;
        w_mc_en_nx   = 1'b0;
        w_mc_rst_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nx   = ST_ISSUE;
                    w_owner_nx   = w_win_id;
                    w_rr_ptr_nx  = ~w_win_id;
                    w_inst_nx    = w_win_inst;
                    w_cnt_nx     = op_cycles(w_win_inst[10:9]);
                    w_gnt0_nx    = ~w_win_id;
                    w_gnt1_nx    = w_win_id;
                    w_mc_en_nx   = 1'b1;
                    w_mc_inst_nx = w_win_inst;
                end else begin
                    w_state_nx   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nx   = ST_RUN;
                w_mc_en_nx   = 1'b1;
                w_mc_inst_nx = r_inst;
            end
            ST_RUN: begin
                if (r_cnt <= 4'd1) begin
                    // Last RUN cycle: capture the overflow and start clearing.
                    w_state_nx  = ST_CLEAR;
                    w_cnt_nx    = 4'(CLR_CYC);
                    w_mc_rst_nx = 1'b1;
                    w_done0_nx  = ~r_owner;
                    w_done1_nx  = r_owner;
                    w_ovf0_nx   = ~r_owner & w_ov;
                    w_ovf1_nx   = r_owner & w_ov;
                end else begin
                    w_cnt_nx     = r_cnt - 4'd1;
                    w_mc_en_nx   = 1'b1;
                    w_mc_inst_nx = r_inst;
                end
            end
            ST_CLEAR: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 4'd0;
                end else begin
                    w_cnt_nx    = r_cnt - 4'd1;
                    w_mc_rst_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = 4'd0;
            end
        endcase
    end

    // State, bookkeeping and output registers. Reset holds the controller in reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_owner   <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_inst    <= 11'd0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_ovf0    <= 1'b0;
            r_ovf1    <= 1'b0;
            r_mc_inst <= 11'd0;
            r_mc_en   <= 1'b0;
            r_mc_rst  <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_owner   <= w_owner_nx;
            r_rr_ptr  <= w_rr_ptr_nx;
            r_inst    <= w_inst_nx;
            r_gnt0    <= w_gnt0_nx;
            r_gnt1    <= w_gnt1_nx;
            r_done0   <= w_done0_nx;
            r_done1   <= w_done1_nx;
            r_ovf0    <= w_ovf0_nx;
            r_ovf1    <= w_ovf1_nx;
            r_mc_inst <= w_mc_inst_nx;
            r_mc_en   <= w_mc_en_nx;
            r_mc_rst  <= w_mc_rst_nx;
        end
    end

    assign bus.GNT0    = r_gnt0;
    assign bus.GNT1    = r_gnt1;
    assign bus.DONE0   = r_done0;
    assign bus.DONE1   = r_done1;
    assign bus.OVF0    = r_ovf0;
    assign bus.OVF1    = r_ovf1;
    assign bus.MC_INST = r_mc_inst;
    assign bus.MC_EN   = r_mc_en;
    assign bus.MC_RST  = r_mc_rst;

endmodule

// File: tb/tb_mc_issue_arbiter.sv
// Self-checking bench for mc_issue_arbiter. A transaction-level model
// records each grant (owner, instruction, grant cycle) and the cycle at
// which the arbiter is free again. From that record it derives the
// expected output vector for every cycle. Inputs change 1 time unit after
// the rising edge, and outputs are sampled on the falling edge.
module tb_mc_issue_arbiter;

    localparam int RC = 3;
    localparam int WC = 3;
    localparam int AC = 6;
    localparam int CC = 1;

    logic CLK;
    logic RST_N;

    mc_issue_arbiter_if bus();

    mc_issue_arbiter #(
        .READ_CYC (RC),
        .WRITE_CYC(WC),
        .ALU_CYC  (AC),
        .CLR_CYC  (CC)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    // Free-running clock with a period of 10.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transaction model state.
    bit          m_hold = 1'b1;   // outputs still at reset values
    bit          m_has  = 1'b0;
    int          m_g    = 0;      // cycle in which GNT is high
    int          m_n    = 0;      // run length for the opcode
    int          m_free = 0;      // first idle cycle after the transaction
    bit          m_owner = 1'b0;
    bit          m_pref  = 1'b0;
    logic [10:0] m_inst  = 11'd0;
    bit          m_ov    = 1'b0;
    int          m_gq[$];

    function automatic int op_len(input logic [1:0] op);
        if (op == 2'b00) return RC;
        if (op == 2'b01) return WC;
        return AC;
    endfunction

    // Layout: GNT0 GNT1 DONE0 DONE1 OVF0 OVF1 MC_EN MC_RST MC_INST[10:0]
    function automatic logic [18:0] act_vec();
        return {bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.OVF0, bus.OVF1,
                bus.MC_EN, bus.MC_RST, bus.MC_INST};
    endfunction

    function automatic logic [18:0] exp_vec();
        logic [18:0] v;
        v = 19'd0;
        if (m_hold) begin
            v[11] = 1'b1;
        end else if (m_has && cyc >= m_g && cyc <= m_g + m_n + CC) begin
            if (cyc == m_g) begin
                if (m_owner) v[17] = 1'b1;
                else         v[18] = 1'b1;
            end
            if (cyc <= m_g + m_n) begin
                v[12]   = 1'b1;
                v[10:0] = m_inst;
            end else begin
                v[11] = 1'b1;
                if (cyc == m_g + m_n + 1) begin
                    if (m_owner) begin v[15] = 1'b1; v[13] = m_ov; end
                    else         begin v[16] = 1'b1; v[14] = m_ov; end
                end
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        m_hold = 1'b1;
        m_has  = 1'b0;
        m_free = cyc;
        m_pref = 1'b0;
    endtask

    // Advance the model with the inputs that the coming rising edge samples.
    task automatic model_advance();
        bit w;
        if (RST_N !== 1'b1) return;
        if (m_has && cyc == m_g + m_n) m_ov = bus.MC_OV & m_inst[10];
        m_hold = 1'b0;
        if (cyc >= m_free && (bus.REQ0 || bus.REQ1)) begin
            if (bus.REQ0 && bus.REQ1) w = m_pref;
            else                      w = bus.REQ1;
            m_pref  = ~w;
            m_owner = w;
            m_inst  = w ? bus.INST1 : bus.INST0;
            m_n     = op_len(m_inst[10:9]);
            m_g     = cyc + 1;
            m_free  = m_g + m_n + CC + 1;
            m_has   = 1'b1;
            m_gq.push_back(int'(w));
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        for (int k = 0; k < 40 && (m_hold || cyc < m_free); k++) tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            checks++;
            if (bus.MC_RST !== 1'b1 || bus.MC_EN !== 1'b0 || bus.GNT0 !== 1'b0 || bus.DONE1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_values got rst=%b en=%b want rst=1 en=0", bus.MC_RST, bus.MC_EN);
            end
            tick();
        end
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL release_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_read();
        int c0, gc, en_run, dn;
        bit drop, ovf;
        gc = -1; en_run = 0; dn = 0; drop = 1'b0; ovf = 1'b1;
        bus.REQ0  = 1'b1;
        bus.INST0 = 11'b00001000000;
        bus.MC_OV = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (drop) bus.REQ0 = 1'b0;
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL read_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (bus.GNT0) begin gc = cyc; drop = 1'b1; end
            else if (gc >= 0 && bus.MC_EN) en_run++;
            if (bus.DONE0) begin dn++; ovf = bus.OVF0; end
            tick();
        end
        bus.MC_OV = 1'b0;
        checks++;
        if (gc != c0 + 1) begin failures++; $display("FAIL read_gnt_latency got=%0d want=%0d", gc, c0 + 1); end
        checks++;
        if (en_run != RC) begin failures++; $display("FAIL read_en_len got=%0d want=%0d", en_run, RC); end
        checks++;
        if (dn != 1) begin failures++; $display("FAIL read_done_count got=%0d want=1", dn); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL read_ovf got=%b want=0", ovf); end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        int q0, en_cnt;
        bit counting;
        drain();
        q0 = m_gq.size();
        en_cnt = 0; counting = 1'b0;
        bus.REQ0  = 1'b1;
        bus.REQ1  = 1'b1;
        bus.INST0 = 11'b01001001111;
        bus.INST1 = 11'b10101001011;
        for (int i = 0; i < 60; i++) begin
            bus.MC_OV = 1'($urandom_range(0, 1));
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            checks++;
            if (bus.GNT0 && bus.GNT1) begin failures++; $display("FAIL b2b_overlap cyc=%0d got=11 want=not both", cyc); end
            if (counting && bus.MC_EN && !bus.GNT1) en_cnt++;
            if (counting && !bus.MC_EN) begin
                checks++;
                if (en_cnt != AC) begin failures++; $display("FAIL add_en_len got=%0d want=%0d", en_cnt, AC); end
                counting = 1'b0;
            end
            if (bus.GNT1) begin counting = 1'b1; en_cnt = 0; end
            if (bus.GNT0) dq.push_back(0);
            if (bus.GNT1) dq.push_back(1);
            tick();
        end
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        checks++;
        if (dq.size() < 4) begin failures++; $display("FAIL b2b_grant_count got=%0d want>=4", dq.size()); end
        for (int i = 0; i < dq.size(); i++) begin
            checks++;
            if (q0 + i >= m_gq.size() || dq[i] != m_gq[q0 + i]) begin
                failures++;
                $display("FAIL b2b_order idx=%0d got=%0d", i, dq[i]);
            end
            if (i > 0) begin
                checks++;
                if (dq[i] == dq[i-1]) begin failures++; $display("FAIL b2b_alternate idx=%0d got=%0d want=%0d", i, dq[i], 1 - dq[i-1]); end
            end
        end
    endtask

    task automatic test_overflow();
        int dcount;
        bit drop, rearm, granted;
        bit ovfs[2];
        drain();
        dcount = 0; drop = 1'b0; rearm = 1'b0; granted = 1'b0;
        ovfs[0] = 1'b0; ovfs[1] = 1'b1;
        bus.REQ1  = 1'b1;
        bus.INST1 = 11'b11111011101;
        bus.MC_OV = 1'b1;
        for (int i = 0; i < 40 && dcount < 2; i++) begin
            if (drop)  begin bus.REQ1 = 1'b0; drop = 1'b0; end
            if (rearm) begin bus.REQ1 = 1'b1; bus.INST1 = 11'b00000000101; rearm = 1'b0; end
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL ovf_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (bus.GNT1) begin drop = 1'b1; granted = 1'b1; end
            if (bus.DONE1 && granted) begin
                ovfs[dcount] = bus.OVF1;
                dcount++;
                if (dcount == 1) rearm = 1'b1;
            end
            tick();
        end
        bus.REQ1  = 1'b0;
        bus.MC_OV = 1'b0;
        checks++;
        if (dcount != 2) begin failures++; $display("FAIL ovf_done_count got=%0d want=2", dcount); end
        checks++;
        if (ovfs[0] !== 1'b1) begin failures++; $display("FAIL ovf_sub got=%b want=1", ovfs[0]); end
        checks++;
        if (ovfs[1] !== 1'b0) begin failures++; $display("FAIL ovf_read got=%b want=0", ovfs[1]); end
    endtask

    task automatic test_reset_abort();
        int gc, first, spurious;
        bit drop, aborted;
        drain();
        gc = -1; first = -1; spurious = 0; drop = 1'b0; aborted = 1'b0;
        bus.REQ0  = 1'b1;
        bus.INST0 = 11'b10101001011;
        bus.MC_OV = 1'b0;
        for (int i = 0; i < 12 && !aborted; i++) begin
            if (drop) bus.REQ0 = 1'b0;
            if (gc >= 0 && cyc == gc + 3) begin
                RST_N = 1'b0;
                model_reset();
                aborted = 1'b1;
            end
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL abort_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (aborted) begin
                checks++;
                if (bus.MC_EN !== 1'b0 || bus.MC_RST !== 1'b1 || bus.DONE0 !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_immediate got en=%b rst=%b done=%b want en=0 rst=1 done=0",
                             bus.MC_EN, bus.MC_RST, bus.DONE0);
                end
            end
            if (bus.GNT0) begin gc = cyc; drop = 1'b1; end
            tick();
        end
        checks++;
        if (!aborted) begin failures++; $display("FAIL abort_reached got=0 want=1"); end
        RST_N     = 1'b1;
        bus.REQ0  = 1'b1;
        bus.REQ1  = 1'b1;
        bus.INST0 = 11'b00001000000;
        bus.INST1 = 11'b00001000001;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL post_abort_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (first < 0 && (bus.DONE0 || bus.DONE1)) spurious++;
            if (first < 0 && bus.GNT0) first = 0;
            if (first < 0 && bus.GNT1) first = 1;
            tick();
        end
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        checks++;
        if (first != 0) begin failures++; $display("FAIL abort_first_grant got=%0d want=0", first); end
        checks++;
        if (spurious != 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", spurious); end
    endtask

    task automatic test_pending_drop();
        int gq[$];
        int g1, pulse_at;
        drain();
        g1 = 0; pulse_at = -1;
        bus.REQ0  = 1'b1;
        bus.INST0 = 11'b00001000000;
        bus.REQ1  = 1'b0;
        bus.INST1 = 11'b01000000011;
        for (int i = 0; i < 40; i++) begin
            bus.REQ1 = (cyc == pulse_at) ? 1'b1 : 1'b0;
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL pending_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            if (bus.GNT1) g1++;
            if (bus.GNT0) begin
                gq.push_back(cyc);
                if (pulse_at < 0) pulse_at = cyc + 1;
            end
            tick();
        end
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        checks++;
        if (g1 != 0) begin failures++; $display("FAIL pending_no_gnt1 got=%0d want=0", g1); end
        checks++;
        if (gq.size() < 4) begin failures++; $display("FAIL single_grant_count got=%0d want>=4", gq.size()); end
        for (int i = 1; i < gq.size(); i++) begin
            checks++;
            if (gq[i] - gq[i-1] != RC + CC + 2) begin
                failures++;
                $display("FAIL single_spacing idx=%0d got=%0d want=%0d", i, gq[i] - gq[i-1], RC + CC + 2);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (RST_N == 1'b0) begin
                RST_N = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                RST_N = 1'b0;
                model_reset();
            end
            bus.REQ0  = ($urandom_range(0, 2) != 0);
            bus.REQ1  = ($urandom_range(0, 2) != 0);
            bus.INST0 = 11'($urandom);
            bus.INST1 = 11'($urandom);
            bus.MC_OV = 1'($urandom_range(0, 1));
            @(negedge CLK);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_trace cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
            checks++;
            if (bus.GNT0 && bus.GNT1) begin failures++; $display("FAIL random_overlap cyc=%0d got=11 want=not both", cyc); end
            tick();
        end
        RST_N = 1'b1;
        drain();
    endtask

    // Test sequence.
    initial begin
        RST_N     = 1'b0;
        bus.REQ0  = 1'b0;
        bus.REQ1  = 1'b0;
        bus.INST0 = 11'd0;
        bus.INST1 = 11'd0;
        bus.MC_OV = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_read();
        test_back_to_back();
        test_overflow();
        test_reset_abort();
        test_pending_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "time limit reached");
    end

endmodule
